// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
// Holds the control FSM state encoding, the register-index width and
// the {En, Flush} pair that drives one pipeline register group.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

  // Enable and synchronous clear for one pipeline register group.
  typedef struct packed {
    logic en;
    logic flush;
  } preg_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare.
// Ports:
//   i_id_rs1, i_id_rs2           source register indices of the ID instruction
//   i_id_uses_rs1, i_id_uses_rs2 the ID instruction really reads that source
//   i_ex_rd                      destination register of the EX instruction
//   i_ex_mem_read                the EX instruction is a load
//   o_load_use                   ID must wait one cycle for the load data
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  input  logic                 i_id_uses_rs1,
  input  logic                 i_id_uses_rs2,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic                 i_ex_mem_read,
  output logic                 o_load_use
);

  logic w_rd_nonzero;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hard-wired to zero, so a load targeting it never produces data to wait for.
  assign w_rd_nonzero = (i_ex_rd != '0);
  assign w_rs1_hit    = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit    = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_load_use   = i_ex_mem_read && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller.
// Drives PC enable and the En/Flush pairs of the IF/ID, ID/EX and EX/MEM
// register groups. Handles taken-branch squashing, load-use bubbles and
// multi-cycle multiply stalls, and counts stalled cycles (saturating).
// Ports:
//   Clk, Rst                         clock, synchronous active-high reset
//   IdRs1/IdRs2, IdUsesRs1/IdUsesRs2 ID-stage source operands
//   ExRd, ExMemRead                  EX-stage destination / load flag
//   ExMulStart                       first EX cycle of a multiply
//   BranchTaken                      taken branch/jump resolved in EX
//   PcEn, *En, *Flush                pipeline register controls
//   MulBusy, MulDone                 multiply stall in progress / result valid pulse
//   StallCycles                      saturating count of cycles with PcEn=0
//
// state    | meaning
// RUN      | normal flow; branch, multiply start and load-use are evaluated
// MUL_BUSY | multiply occupying EX; front end held, bubbles sent to MEM
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [REG_IDX_W-1:0] IdRs1,
  input  logic [REG_IDX_W-1:0] IdRs2,
  input  logic                 IdUsesRs1,
  input  logic                 IdUsesRs2,
  input  logic [REG_IDX_W-1:0] ExRd,
  input  logic                 ExMemRead,
  input  logic                 ExMulStart,
  input  logic                 BranchTaken,
  output logic                 PcEn,
  output logic                 IfIdEn,
  output logic                 IdExEn,
  output logic                 ExMemEn,
  output logic                 IfIdFlush,
  output logic                 IdExFlush,
  output logic                 ExMemFlush,
  output logic                 MulBusy,
  output logic                 MulDone,
  output logic [CNT_W-1:0]     StallCycles
);

  // The start cycle is the first of MUL_LAT-1 stall cycles, so the busy
  // state only has to cover the remaining MUL_LAT-2 of them.
  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 2);

  state_e           r_state;
  state_e           w_next_state;
  logic [3:0]       r_mul_cnt;
  logic [3:0]       w_next_cnt;
  logic             r_mul_done;
  logic             w_done_set;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_load_use;
  logic       w_mul_stall;
  logic       w_pc_en;
  logic       w_mul_busy;
  preg_ctrl_t w_if_id;
  preg_ctrl_t w_id_ex;
  preg_ctrl_t w_ex_mem;

  hazard_detect u_hazard_detect (
    .i_id_rs1      (IdRs1),
    .i_id_rs2      (IdRs2),
    .i_id_uses_rs1 (IdUsesRs1),
    .i_id_uses_rs2 (IdUsesRs2),
    .i_ex_rd       (ExRd),
    .i_ex_mem_read (ExMemRead),
    .o_load_use    (w_load_use)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_mul_cnt;
    w_done_set   = 1'b0;
    w_mul_stall  = 1'b0;
    w_pc_en      = 1'b0;
    w_mul_busy   = 1'b0;
    w_if_id      = '0;
    w_id_ex      = '0;
    w_ex_mem     = '0;

    if (!Rst) begin
      case (r_state)
        RUN: begin
          if (BranchTaken) begin
            // Let the PC load the target while squashing the two younger instructions.
            w_pc_en  = 1'b1;
            w_if_id  = '{en: 1'b1, flush: 1'b1};
            w_id_ex  = '{en: 1'b1, flush: 1'b1};
            w_ex_mem = '{en: 1'b1, flush: 1'b0};
          end else if (ExMulStart) begin
            w_mul_stall = 1'b1;
            if (MUL_LAT == 2) begin
              w_done_set = 1'b1;
            end else begin
              w_next_state = MUL_BUSY;
              w_next_cnt   = MUL_INIT;
            end
          end else if (w_load_use) begin
            // Hold IF/ID and PC, inject one bubble into EX.
            w_if_id  = '{en: 1'b0, flush: 1'b0};
            w_id_ex  = '{en: 1'b1, flush: 1'b1};
            w_ex_mem = '{en: 1'b1, flush: 1'b0};
          end else begin
            w_pc_en  = 1'b1;
            w_if_id  = '{en: 1'b1, flush: 1'b0};
            w_id_ex  = '{en: 1'b1, flush: 1'b0};
            w_ex_mem = '{en: 1'b1, flush: 1'b0};
          end
        end
        MUL_BUSY: begin
          w_mul_stall = 1'b1;
          w_next_cnt  = r_mul_cnt - 4'd1;
          if (r_mul_cnt == 4'd1) begin
            w_next_state = RUN;
            w_done_set   = 1'b1;
          end
        end
        default: w_next_state = RUN;
      endcase

      // Multiply stall: front end frozen, EX held by the multiplier, MEM gets bubbles.
      if (w_mul_stall) begin
        w_pc_en    = 1'b0;
        w_mul_busy = 1'b1;
        w_if_id    = '{en: 1'b0, flush: 1'b0};
        w_id_ex    = '{en: 1'b0, flush: 1'b0};
        w_ex_mem   = '{en: 1'b1, flush: 1'b1};
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= RUN;
      r_mul_cnt   <= '0;
      r_mul_done  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_mul_cnt  <= w_next_cnt;
      r_mul_done <= w_done_set;
      if (!w_pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign PcEn        = w_pc_en;
  assign IfIdEn      = w_if_id.en;
  assign IdExEn      = w_id_ex.en;
  assign ExMemEn     = w_ex_mem.en;
  assign IfIdFlush   = w_if_id.flush;
  assign IdExFlush   = w_id_ex.flush;
  assign ExMemFlush  = w_ex_mem.flush;
  assign MulBusy     = w_mul_busy;
  // Gated so that a reset landing on the done cycle still reads as zero.
  assign MulDone     = r_mul_done && !Rst;
  assign StallCycles = r_stall_cnt;

  // The front end is frozen during a multiply, so a branch cannot resolve here.
  a_no_branch_in_mul : assert property (@(posedge Clk) disable iff (Rst)
    !(r_state == MUL_BUSY && BranchTaken));

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  import pipe_ctrl_pkg::*;

  logic                 Clk = 1'b0;
  logic                 Rst;
  logic [REG_IDX_W-1:0] IdRs1, IdRs2, ExRd;
  logic                 IdUsesRs1, IdUsesRs2, ExMemRead, ExMulStart, BranchTaken;

  // DUT a: MUL_LAT=4, CNT_W=32; DUT b: MUL_LAT=2; DUT c: CNT_W=4.
  logic a_PcEn, a_IfIdEn, a_IdExEn, a_ExMemEn, a_IfIdFl, a_IdExFl, a_ExMemFl, a_Busy, a_Done;
  logic b_PcEn, b_IfIdEn, b_IdExEn, b_ExMemEn, b_IfIdFl, b_IdExFl, b_ExMemFl, b_Busy, b_Done;
  logic c_PcEn, c_IfIdEn, c_IdExEn, c_ExMemEn, c_IfIdFl, c_IdExFl, c_ExMemFl, c_Busy, c_Done;
  logic [31:0] a_Stall, b_Stall;
  logic [3:0]  c_Stall;
  logic [7:0]  a_ctl, b_ctl;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  hazard_stall_ctrl #(.MUL_LAT(4), .CNT_W(32)) u_a (
    .Clk(Clk), .Rst(Rst), .IdRs1(IdRs1), .IdRs2(IdRs2), .IdUsesRs1(IdUsesRs1),
    .IdUsesRs2(IdUsesRs2), .ExRd(ExRd), .ExMemRead(ExMemRead), .ExMulStart(ExMulStart),
    .BranchTaken(BranchTaken), .PcEn(a_PcEn), .IfIdEn(a_IfIdEn), .IdExEn(a_IdExEn),
    .ExMemEn(a_ExMemEn), .IfIdFlush(a_IfIdFl), .IdExFlush(a_IdExFl), .ExMemFlush(a_ExMemFl),
    .MulBusy(a_Busy), .MulDone(a_Done), .StallCycles(a_Stall));

  hazard_stall_ctrl #(.MUL_LAT(2), .CNT_W(32)) u_b (
    .Clk(Clk), .Rst(Rst), .IdRs1(IdRs1), .IdRs2(IdRs2), .IdUsesRs1(IdUsesRs1),
    .IdUsesRs2(IdUsesRs2), .ExRd(ExRd), .ExMemRead(ExMemRead), .ExMulStart(ExMulStart),
    .BranchTaken(BranchTaken), .PcEn(b_PcEn), .IfIdEn(b_IfIdEn), .IdExEn(b_IdExEn),
    .ExMemEn(b_ExMemEn), .IfIdFlush(b_IfIdFl), .IdExFlush(b_IdExFl), .ExMemFlush(b_ExMemFl),
    .MulBusy(b_Busy), .MulDone(b_Done), .StallCycles(b_Stall));

  hazard_stall_ctrl #(.MUL_LAT(4), .CNT_W(4)) u_c (
    .Clk(Clk), .Rst(Rst), .IdRs1(IdRs1), .IdRs2(IdRs2), .IdUsesRs1(IdUsesRs1),
    .IdUsesRs2(IdUsesRs2), .ExRd(ExRd), .ExMemRead(ExMemRead), .ExMulStart(ExMulStart),
    .BranchTaken(BranchTaken), .PcEn(c_PcEn), .IfIdEn(c_IfIdEn), .IdExEn(c_IdExEn),
    .ExMemEn(c_ExMemEn), .IfIdFlush(c_IfIdFl), .IdExFlush(c_IdExFl), .ExMemFlush(c_ExMemFl),
    .MulBusy(c_Busy), .MulDone(c_Done), .StallCycles(c_Stall));

  // {PcEn, IfIdEn, IdExEn, ExMemEn, IfIdFlush, IdExFlush, ExMemFlush, MulBusy}
  assign a_ctl = {a_PcEn, a_IfIdEn, a_IdExEn, a_ExMemEn, a_IfIdFl, a_IdExFl, a_ExMemFl, a_Busy};
  assign b_ctl = {b_PcEn, b_IfIdEn, b_IdExEn, b_ExMemEn, b_IfIdFl, b_IdExFl, b_ExMemFl, b_Busy};

  localparam logic [7:0] CTL_RUN    = 8'b1111_0000;
  localparam logic [7:0] CTL_LU     = 8'b0011_0100;
  localparam logic [7:0] CTL_BRANCH = 8'b1111_1100;
  localparam logic [7:0] CTL_MUL    = 8'b0001_0011;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mrd, mul, br;
    logic [7:0] exp_ctl;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, rs2, rd, input logic u1, u2, mrd, mul, br);
    IdRs1 = rs1; IdRs2 = rs2; ExRd = rd;
    IdUsesRs1 = u1; IdUsesRs2 = u2; ExMemRead = mrd; ExMulStart = mul; BranchTaken = br;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Drive at negedge, sample 1 ns later (well before the next posedge).
  task automatic next_cycle();
    @(negedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    idle();
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    int exp_stall;
    Rst = 1'b1;
    idle();

    vecs[0]  = '{rs1:0, rs2:0, rd:0, u1:0, u2:0, mrd:0, mul:0, br:0, exp_ctl:CTL_RUN};
    vecs[1]  = '{rs1:0, rs2:5, rd:5, u1:0, u2:1, mrd:1, mul:0, br:0, exp_ctl:CTL_LU};
    vecs[2]  = '{rs1:0, rs2:0, rd:0, u1:0, u2:0, mrd:0, mul:0, br:0, exp_ctl:CTL_RUN};
    vecs[3]  = '{rs1:0, rs2:0, rd:0, u1:0, u2:1, mrd:1, mul:0, br:0, exp_ctl:CTL_RUN};
    vecs[4]  = '{rs1:0, rs2:5, rd:5, u1:0, u2:0, mrd:1, mul:0, br:0, exp_ctl:CTL_RUN};
    vecs[5]  = '{rs1:9, rs2:3, rd:9, u1:1, u2:1, mrd:1, mul:0, br:0, exp_ctl:CTL_LU};
    vecs[6]  = '{rs1:7, rs2:3, rd:7, u1:0, u2:1, mrd:1, mul:0, br:0, exp_ctl:CTL_RUN};
    vecs[7]  = '{rs1:7, rs2:3, rd:7, u1:1, u2:1, mrd:0, mul:0, br:0, exp_ctl:CTL_RUN};
    vecs[8]  = '{rs1:4, rs2:4, rd:4, u1:1, u2:1, mrd:1, mul:0, br:1, exp_ctl:CTL_BRANCH};
    vecs[9]  = '{rs1:0, rs2:0, rd:0, u1:0, u2:0, mrd:0, mul:1, br:1, exp_ctl:CTL_BRANCH};
    vecs[10] = '{rs1:0, rs2:0, rd:0, u1:0, u2:0, mrd:0, mul:0, br:0, exp_ctl:CTL_RUN};

    // Reset with random inputs: everything but the counter forced low.
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      Rst = 1'b1;
      set_in(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge Clk);
      #1;
      chk("reset_ctl", {24'd0, a_ctl}, 32'd0);
      chk("reset_done", {31'd0, a_Done}, 32'd0);
      chk("reset_stall", a_Stall, 32'd0);
    end

    // Directed RUN-state vectors.
    @(negedge Clk);
    Rst = 1'b0;
    exp_stall = 0;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge Clk);
      set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
             vecs[i].mrd, vecs[i].mul, vecs[i].br);
      #1;
      chk($sformatf("vec%0d_ctl", i), {24'd0, a_ctl}, {24'd0, vecs[i].exp_ctl});
      chk($sformatf("vec%0d_stall", i), a_Stall, 32'(exp_stall));
      if (vecs[i].exp_ctl[7] == 1'b0) exp_stall++;
    end
    @(negedge Clk);
    idle();
    #1;
    chk("table_stall_total", a_Stall, 32'(exp_stall));

    // Multiply: a (MUL_LAT=4) and b (MUL_LAT=2) see the same start pulse.
    do_reset();
    ExMulStart = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) begin
        @(negedge Clk);
        ExMulStart = 1'b0;
      end
      #1;
      chk($sformatf("mul4_k%0d_ctl", k), {24'd0, a_ctl}, {24'd0, (k < 3) ? CTL_MUL : CTL_RUN});
      chk($sformatf("mul4_k%0d_done", k), {31'd0, a_Done}, {31'd0, (k == 3)});
      chk($sformatf("mul2_k%0d_ctl", k), {24'd0, b_ctl}, {24'd0, (k < 1) ? CTL_MUL : CTL_RUN});
      chk($sformatf("mul2_k%0d_done", k), {31'd0, b_Done}, {31'd0, (k == 1)});
    end
    chk("mul4_stall", a_Stall, 32'd3);
    chk("mul2_stall", b_Stall, 32'd1);

    // Reset in the second cycle of a multiply aborts it with no done pulse.
    do_reset();
    ExMulStart = 1'b1;
    #1;
    chk("abort_start_busy", {31'd0, a_Busy}, 32'd1);
    @(negedge Clk);
    ExMulStart = 1'b0;
    Rst = 1'b1;
    #1;
    chk("abort_rst_ctl", {24'd0, a_ctl}, 32'd0);
    chk("abort_rst_done_b", {31'd0, b_Done}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      Rst = 1'b0;
      #1;
      chk($sformatf("abort_k%0d_ctl", k), {24'd0, a_ctl}, {24'd0, CTL_RUN});
      chk($sformatf("abort_k%0d_done", k), {31'd0, a_Done}, 32'd0);
    end

    // Saturation: hold a load-use stall; c (CNT_W=4) must stop at 15.
    do_reset();
    set_in(5'd0, 5'd6, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 20; k++) begin
      if (k != 0) @(negedge Clk);
      #1;
      chk($sformatf("sat_k%0d", k), {28'd0, c_Stall}, (k < 15) ? 32'(k) : 32'd15);
    end
    chk("sat_wide_ref", a_Stall, 32'd20);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
